// File: rtl/fft_pkg.sv
// Shared defaults, error codes and FSM state type for the FFT result capture path.
package fft_pkg;

  localparam int NN_DEFAULT   = 32;
  localparam int DW_DEFAULT   = 16;
  localparam int EXPW_DEFAULT = 6;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_EARLY_EOP = 2'd1;
  localparam logic [1:0] ERR_NO_EOP    = 2'd2;
  localparam logic [1:0] ERR_SOP       = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/fft_mag2.sv
// Two-stage squared-magnitude pipeline: squares registered, then their sum.
// A write-valid bit and an opaque tag word travel alongside the data.
module fft_mag2 #(
  parameter int DW = 16,
  parameter int TW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [DW-1:0]   i_re,
  input  logic [DW-1:0]   i_im,
  input  logic [TW-1:0]   i_tag,
  output logic            o_valid,
  output logic [2*DW:0]   o_mag,
  output logic [TW-1:0]   o_tag
);

  logic signed [2*DW-1:0] w_re_x;
  logic signed [2*DW-1:0] w_im_x;
  logic        [2*DW-1:0] r_sq_re;
  logic        [2*DW-1:0] r_sq_im;
  logic                   r_v1;
  logic        [TW-1:0]   r_tag1;
  logic                   r_v2;
  logic        [2*DW:0]   r_mag;
  logic        [TW-1:0]   r_tag2;

  // Sign-extend before multiplying so the most negative input squares exactly.
  assign w_re_x = {{DW{i_re[DW-1]}}, i_re};
  assign w_im_x = {{DW{i_im[DW-1]}}, i_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_sq_re <= '0;
      r_sq_im <= '0;
      r_tag1  <= '0;
      r_v2    <= 1'b0;
      r_mag   <= '0;
      r_tag2  <= '0;
    end else begin
      r_v1    <= i_valid;
      r_sq_re <= w_re_x * w_re_x;
      r_sq_im <= w_im_x * w_im_x;
      r_tag1  <= i_tag;
      r_v2    <= r_v1;
      r_mag   <= {1'b0, r_sq_re} + {1'b0, r_sq_im};
      r_tag2  <= r_tag1;
    end
  end

  assign o_valid = r_v2;
  assign o_mag   = r_mag;
  assign o_tag   = r_tag2;

endmodule

// File: rtl/fft_result_capture.sv
// Captures FFT result frames, checks sop/eop framing and writes tagged
// squared-magnitude words to the result FIFO.
module fft_result_capture
  import fft_pkg::*;
#(
  parameter int NN   = NN_DEFAULT,
  parameter int DW   = DW_DEFAULT,
  parameter int EXPW = EXPW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            source_valid,
  input  logic            source_sop,
  input  logic            source_eop,
  input  logic [DW-1:0]   source_real,
  input  logic [DW-1:0]   source_imag,
  input  logic [EXPW-1:0] source_exp,
  input  logic [1:0]      source_error,
  output logic            source_ready,
  input  logic            out_fifo_afull,
  output logic            out_wr,
  output logic [2*DW:0]   out_data,
  output logic [EXPW-1:0] out_exp,
  output logic            out_sop,
  output logic            out_eop,
  output logic            out_err,
  output logic            frame_done,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic [15:0]     frame_cnt
);

  localparam int             IW   = $clog2(NN);
  localparam int             TW   = EXPW + 7;
  localparam logic [IW-1:0]  LAST = IW'(NN - 1);

  state_t          r_state, w_state_next;
  logic [IW-1:0]   r_idx, w_idx_next;
  logic [EXPW-1:0] r_exp, w_exp_next;
  logic            w_acc, w_last, w_start;
  logic            w_wr, w_sop, w_eop, w_err, w_done, w_ferr;
  logic [1:0]      w_code;
  logic [TW-1:0]   w_tag;

  logic            r_b_valid;
  logic [DW-1:0]   r_b_re, r_b_im;
  logic [TW-1:0]   r_b_tag;
  logic            w_m_valid;
  logic [2*DW:0]   w_m_mag;
  logic [TW-1:0]   w_m_tag;
  logic [1:0]      r_err_code;
  logic [15:0]     r_frame_cnt;

  assign source_ready = !rst && !out_fifo_afull;
  assign w_acc        = source_valid && source_ready;
  assign w_last       = (r_idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_exp   <= w_exp_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_exp_next   = r_exp;
    w_start      = 1'b0;
    w_wr         = 1'b0;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_err        = 1'b0;
    w_done       = 1'b0;
    w_ferr       = 1'b0;
    w_code       = ERR_NONE;
    if (w_acc) begin
      case (r_state)
        ST_IDLE: w_start = source_sop;
        ST_DRAIN: begin
          if (source_eop) w_state_next = ST_IDLE;
          else            w_start      = source_sop;
        end
        ST_CAPTURE: begin
          if (source_error != 2'b00) begin
            w_wr         = 1'b1;
            w_eop        = 1'b1;
            w_err        = 1'b1;
            w_ferr       = 1'b1;
            w_code       = ERR_SOP;
            w_state_next = source_eop ? ST_IDLE : ST_DRAIN;
          end else if (source_sop) begin
            // Abandoned frame: flag it, then treat this beat as a fresh start.
            w_ferr  = 1'b1;
            w_code  = ERR_SOP;
            w_start = 1'b1;
          end else begin
            w_wr = 1'b1;
            if (source_eop) begin
              w_eop        = 1'b1;
              w_state_next = ST_IDLE;
              if (w_last) begin
                w_done = 1'b1;
              end else begin
                w_err  = 1'b1;
                w_ferr = 1'b1;
                w_code = ERR_EARLY_EOP;
              end
            end else if (w_last) begin
              w_eop        = 1'b1;
              w_err        = 1'b1;
              w_ferr       = 1'b1;
              w_code       = ERR_NO_EOP;
              w_state_next = ST_DRAIN;
            end else begin
              w_idx_next = r_idx + IW'(1);
            end
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
    if (w_start) begin
      w_wr         = 1'b1;
      w_sop        = 1'b1;
      w_exp_next   = source_exp;
      w_idx_next   = IW'(1);
      w_state_next = ST_CAPTURE;
    end
  end

  assign w_tag = {w_code, w_ferr, w_done, w_err, w_eop, w_sop, w_exp_next};

  // Beat register ahead of the magnitude pipeline; status pulses ride in the tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_re    <= '0;
      r_b_im    <= '0;
      r_b_tag   <= '0;
    end else begin
      r_b_valid <= w_wr;
      r_b_re    <= source_real;
      r_b_im    <= source_imag;
      r_b_tag   <= w_tag;
    end
  end

  fft_mag2 #(
    .DW (DW),
    .TW (TW)
  ) u_mag2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_b_valid),
    .i_re    (r_b_re),
    .i_im    (r_b_im),
    .i_tag   (r_b_tag),
    .o_valid (w_m_valid),
    .o_mag   (w_m_mag),
    .o_tag   (w_m_tag)
  );

  assign out_wr     = w_m_valid;
  assign out_data   = w_m_mag;
  assign out_exp    = w_m_tag[EXPW-1:0];
  assign out_sop    = w_m_tag[EXPW];
  assign out_eop    = w_m_tag[EXPW+1];
  assign out_err    = w_m_tag[EXPW+2];
  assign frame_done = w_m_tag[EXPW+3];
  assign frame_err  = w_m_tag[EXPW+4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_code  <= ERR_NONE;
      r_frame_cnt <= '0;
    end else begin
      if (frame_err)  r_err_code  <= w_m_tag[EXPW+6:EXPW+5];
      if (frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_result_capture.sv
// Randomized bench for fft_result_capture with a frame-level reference model
// and a scoreboard of expected FIFO words.
module tb_fft_result_capture;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               source_valid = 1'b0;
  logic               source_sop = 1'b0;
  logic               source_eop = 1'b0;
  logic signed [15:0] source_real = '0;
  logic signed [15:0] source_imag = '0;
  logic [5:0]         source_exp = '0;
  logic [1:0]         source_error = '0;
  logic               out_fifo_afull = 1'b0;
  logic               source_ready;
  logic               out_wr;
  logic [32:0]        out_data;
  logic [5:0]         out_exp;
  logic               out_sop, out_eop, out_err;
  logic               frame_done, frame_err;
  logic [1:0]         err_code;
  logic [15:0]        frame_cnt;

  fft_result_capture dut (
    .clk(clk), .rst(rst),
    .source_valid(source_valid), .source_sop(source_sop), .source_eop(source_eop),
    .source_real(source_real), .source_imag(source_imag), .source_exp(source_exp),
    .source_error(source_error), .source_ready(source_ready),
    .out_fifo_afull(out_fifo_afull), .out_wr(out_wr), .out_data(out_data),
    .out_exp(out_exp), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
    .frame_done(frame_done), .frame_err(frame_err),
    .err_code(err_code), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [32:0] data;
    logic [5:0]  exp;
    logic        sop, eop, err, done, ferr;
  } rec_t;

  rec_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          wr_total = 0;
  int          done_total = 0;
  int          cyc = 0;
  int          stall_mode = 0;
  bit          m_cap = 0;
  bit          m_drain = 0;
  int          m_pos = 0;
  logic [5:0]  m_exp = '0;
  logic [1:0]  m_err = '0;
  logic [15:0] m_cnt = '0;
  int          m_pushes = 0;
  int          m_dones = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp_v, $time);
  endtask

  // ---------------- reference model ----------------
  task automatic push(input logic signed [15:0] re, input logic signed [15:0] im,
                      input logic s, input logic e, input logic er, input logic d, input logic f);
    rec_t   r;
    longint p;
    p      = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    r.data = p[32:0];
    r.exp  = m_exp;
    r.sop  = s; r.eop = e; r.err = er; r.done = d; r.ferr = f;
    q.push_back(r);
    m_pushes++;
    if (d) m_dones++;
  endtask

  task automatic start_frame(input logic signed [15:0] re, input logic signed [15:0] im,
                             input logic [5:0] ex, input logic f);
    m_exp = ex; m_pos = 1; m_cap = 1; m_drain = 0;
    push(re, im, 1, 0, 0, 0, f);
  endtask

  task automatic model_accept(input logic s, input logic e, input logic signed [15:0] re,
                              input logic signed [15:0] im, input logic [5:0] ex, input logic [1:0] er);
    if (!m_cap) begin
      if (m_drain && e) m_drain = 0;
      else if (s)       start_frame(re, im, ex, 0);
    end else if (er != 2'd0) begin
      push(re, im, 0, 1, 1, 0, 1);
      m_err = 2'd3; m_cap = 0; m_drain = !e;
    end else if (s) begin
      m_err = 2'd3;
      start_frame(re, im, ex, 1);
    end else if (e) begin
      if (m_pos == 31) begin push(re, im, 0, 1, 0, 1, 0); m_cnt = m_cnt + 16'd1; end
      else begin push(re, im, 0, 1, 1, 0, 1); m_err = 2'd1; end
      m_cap = 0;
    end else if (m_pos == 31) begin
      push(re, im, 0, 1, 1, 0, 1);
      m_err = 2'd2; m_cap = 0; m_drain = 1;
    end else begin
      push(re, im, 0, 0, 0, 0, 0);
      m_pos++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive_afull();
    case (stall_mode)
      1:       out_fifo_afull = ((cyc / 7) % 2) == 1;
      2:       out_fifo_afull = ($urandom_range(0, 3) == 0);
      default: out_fifo_afull = 1'b0;
    endcase
  endtask

  task automatic send(input logic s, input logic e, input logic signed [15:0] re,
                      input logic signed [15:0] im, input logic [5:0] ex, input logic [1:0] er);
    bit acc = 0;
    for (int w = 0; w < 100 && !acc; w++) begin
      @(negedge clk);
      cyc++;
      drive_afull();
      source_valid = 1'b1; source_sop = s; source_eop = e;
      source_real = re; source_imag = im; source_exp = ex; source_error = er;
      #1;
      chk("ready", source_ready, !out_fifo_afull);
      if (source_ready) begin
        model_accept(s, e, re, im, ex, er);
        acc = 1;
      end
    end
    if (!acc) chk("ready_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      drive_afull();
      source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'd0;
    end
  endtask

  task automatic frame(input int len, input int eop_at, input int sop_at, input int err_at,
                       input logic [5:0] ex, input bit rnd);
    logic signed [15:0] re, im;
    for (int i = 0; i < len; i++) begin
      re = rnd ? 16'($urandom) : 16'(i);
      im = rnd ? 16'($urandom) : -16'(i);
      send((i == 0) || (i == sop_at), i == eop_at, re, im, ex,
           (i == err_at) ? 2'($urandom_range(1, 3)) : 2'd0);
    end
  endtask

  task automatic settle_check(input string tag, input int exp_wr, input int w0,
                              input int exp_done, input int d0);
    idle(8);
    chk({tag, "_writes"}, wr_total - w0, exp_wr);
    chk({tag, "_done"}, done_total - d0, exp_done);
    chk({tag, "_errcode"}, err_code, m_err);
    chk({tag, "_cnt"}, frame_cnt, m_cnt);
    chk({tag, "_qempty"}, q.size(), 0);
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(posedge clk) begin : mon
    rec_t r;
    #1;
    if (out_wr) begin
      wr_total++;
      if (q.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        r = q.pop_front();
        chk("word", {out_data, out_exp, out_sop, out_eop, out_err, frame_done, frame_err},
            {r.data, r.exp, r.sop, r.eop, r.err, r.done, r.ferr});
      end
    end else if (frame_done || frame_err) begin
      chk("stray_pulse", {frame_done, frame_err}, 2'b00);
    end
    if (frame_done) done_total++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, p0, md0, k;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {out_wr, out_sop, out_eop, out_err, frame_done, frame_err,
                       out_data, out_exp, err_code, frame_cnt}, 0);
    chk("reset_ready", source_ready, 0);
    rst = 1'b0;
    idle(2);

    // Clean frame: bin k = (k, -k), exp 3
    w0 = wr_total; d0 = done_total;
    frame(32, 31, -1, -1, 6'd3, 0);
    settle_check("clean", 32, w0, 1, d0);
    chk("clean_cnt_is_1", frame_cnt, 1);

    // Corner magnitudes
    w0 = wr_total; d0 = done_total;
    send(1, 0, 16'sh8000, 16'sh8000, 6'd5, 2'd0);
    send(0, 0, 16'sh7FFF, 16'sh0000, 6'd5, 2'd0);
    for (int i = 2; i < 32; i++) send(0, i == 31, 16'($urandom), 16'($urandom), 6'd5, 2'd0);
    settle_check("corner", 32, w0, 1, d0);

    // Early eop at bin 20, then a good frame
    w0 = wr_total; d0 = done_total;
    frame(21, 20, -1, -1, 6'd7, 1);
    settle_check("early_eop", 21, w0, 0, d0);
    chk("early_eop_code", err_code, 2'd1);
    w0 = wr_total; d0 = done_total;
    frame(32, 31, -1, -1, 6'd8, 1);
    settle_check("after_early", 32, w0, 1, d0);

    // 40 beats, eop at 39
    w0 = wr_total; d0 = done_total;
    frame(40, 39, -1, -1, 6'd9, 1);
    settle_check("no_eop", 32, w0, 0, d0);
    chk("no_eop_code", err_code, 2'd2);
    w0 = wr_total; d0 = done_total;
    frame(32, 31, -1, -1, 6'd10, 1);
    settle_check("after_no_eop", 32, w0, 1, d0);

    // Sop reasserted at bin 10, afull toggling every 7 cycles
    stall_mode = 1;
    w0 = wr_total; d0 = done_total;
    frame(10, -1, -1, -1, 6'd11, 1);
    frame(32, 31, -1, -1, 6'd12, 1);
    settle_check("resop", 42, w0, 1, d0);
    chk("resop_code", err_code, 2'd3);
    stall_mode = 0;

    // Reset at bin 15
    frame(15, -1, -1, -1, 6'd13, 1);
    @(negedge clk);
    rst = 1'b1; source_valid = 1'b0;
    q.delete(); m_cap = 0; m_drain = 0; m_err = 2'd0; m_cnt = 16'd0;
    @(posedge clk); #1;
    chk("midrst_outs", {out_wr, out_sop, out_eop, out_err, frame_done, frame_err,
                        out_data, out_exp, err_code, frame_cnt}, 0);
    chk("midrst_ready", source_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    w0 = wr_total; d0 = done_total;
    for (int i = 0; i < 3; i++) send(0, i == 2, 16'($urandom), 16'($urandom), 6'd1, 2'd0);
    frame(32, 31, -1, -1, 6'd14, 1);
    settle_check("after_rst", 32, w0, 1, d0);

    // Randomized frames with random stalls
    stall_mode = 2;
    for (int f = 0; f < 10; f++) begin
      w0 = wr_total; d0 = done_total; p0 = m_pushes; md0 = m_dones;
      case ($urandom_range(0, 4))
        0: frame(32, 31, -1, -1, 6'($urandom), 1);
        1: begin k = $urandom_range(1, 30); frame(k + 1, k, -1, -1, 6'($urandom), 1); end
        2: frame(32 + $urandom_range(1, 5), -1, -1, -1, 6'($urandom), 1);
        3: begin k = $urandom_range(1, 30); frame(k, -1, -1, -1, 6'($urandom), 1);
                 frame(32, 31, -1, -1, 6'($urandom), 1); end
        default: begin k = $urandom_range(1, 30); frame(k + 1, -1, -1, k, 6'($urandom), 1); end
      endcase
      settle_check("rand", m_pushes - p0, w0, m_dones - md0, d0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_result_capture.md
# fft_result_capture

Receive side of the FFT streaming interface: accepts the NN-point result frame from the FFT core's Avalon-ST source port, checks sop/eop framing, converts each complex bin to squared magnitude and writes tagged words into the downstream result FIFO. It is the counterpart of the sink-framing generator that starts the FFT from the input FIFO. It sits between the FFT core output and the result FIFO read by the host/display path.

## Interface
Parameters:
- NN, 32: points per frame; legal range 4..1024.
- DW, 16: width of source_real / source_imag (signed).
- EXPW, 6: width of block-floating-point exponent (signed).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- source_valid  in  1  FFT output beat valid.
- source_sop  in  1  first bin of frame.
- source_eop  in  1  last bin of frame.
- source_real  in  DW  real part, signed.
- source_imag  in  DW  imaginary part, signed.
- source_exp  in  EXPW  frame exponent, valid on sop beat.
- source_error  in  2  core error code, nonzero = bad beat.
- source_ready  out  1  beat accepted when source_valid && source_ready.
- out_fifo_afull  in  1  result FIFO almost full; asserted with ≥3 free words.
- out_wr  out  1  write strobe to result FIFO.
- out_data  out  2*DW+1  re²+im², unsigned.
- out_exp  out  EXPW  exponent captured at frame sop.
- out_sop / out_eop / out_err  out  1 each  tags on the written word.
- frame_done  out  1  one-cycle pulse, good frame completed.
- frame_err  out  1  one-cycle pulse, framing/core error.
- err_code  out  2  last error: 1 early eop, 2 missing eop, 3 unexpected sop or source_error.
- frame_cnt  out  16  count of good frames, wraps 0xFFFF→0.

## Operation
- source_ready = !rst && !out_fifo_afull (combinational). Pipeline has 2 words in flight; afull slack covers them.
- States: IDLE, CAPTURE, DRAIN. Bin index idx, clog2(NN) bits.
- IDLE: accepted beats without sop are dropped silently. Sop beat → write with out_sop=1, latch source_exp, idx←1, → CAPTURE.
- CAPTURE, per accepted beat (priority order):
  - source_error≠0: err 3; if eop → IDLE, else → DRAIN; beat written with out_eop=1, out_err=1.
  - sop: err 3 (abandoned frame); beat starts new frame: out_sop=1, out_err=0, exponent relatched, idx←1, stay.
  - eop && idx==NN-1: written out_eop=1; frame_done, frame_cnt+1; → IDLE.
  - eop && idx<NN-1: err 1; written out_eop=1, out_err=1; → IDLE.
  - !eop && idx==NN-1: err 2; written out_eop=1, out_err=1; → DRAIN.
  - else written, idx+1.
- DRAIN: beats not written; beat with eop → IDLE; beat with sop (no eop) → handled as IDLE sop.
- Arithmetic: full-precision signed squares (2*DW bits each), unsigned sum 2*DW+1 bits; no truncation; (-2^(DW-1))² must be exact.
- err_code holds until next error or reset.

## Timing
- Beat accepted at edge t → out_wr/out_data/tags valid after edge t+2, one-cycle strobe per beat; back-to-back beats give back-to-back writes.
- frame_done / frame_err pulse in the same cycle as out_wr of the triggering beat (err on drained beats: t+2 with out_wr=0).
- Reset values: out_wr, out_sop, out_eop, out_err, frame_done, frame_err = 0; out_data, out_exp = 0; err_code = 0; frame_cnt = 0; state IDLE; pipeline valid bits cleared. source_ready = 0 while rst high.
- Reset mid-frame: in-flight words discarded (no out_wr after rst edge), partial frame lost without frame_err; next frame must begin with sop.
- out_fifo_afull rising mid-frame only stalls; no error, no loss.

## Structure
- Package fft_pkg: NN, DW, EXPW defaults, err code constants (ERR_NONE, ERR_EARLY_EOP, ERR_NO_EOP, ERR_SOP), state enum.
- Sub-module fft_mag2: 2-stage pipeline (squares registered, then sum registered) carrying a valid bit and tag sideband; top holds FSM, counters, exponent latch.

## Test plan
- Clean frame, NN=32, bin k = (k, -k), exp=3 → 32 writes, out_data=2k², out_sop on k=0, out_eop on k=31, out_exp=3, frame_done once, frame_cnt=1.
- Corner values re=im=-32768 → out_data=0x8000_0000; re=32767, im=0 → 0x3FFF_0001.
- Eop at bin 20 → 21 writes, last with out_eop=1,out_err=1, err_code=1, frame_err pulse, frame_cnt unchanged; following good frame counts.
- 40 beats no eop, eop at 39 → 32 writes, err_code=2, beats 32..39 not written, next sop frame accepted.
- Sop reasserted at bin 10, then 32 clean bins → err_code=3, 42 writes, second frame frame_done; afull toggled every 7 cycles → source_ready stalls, no words lost or duplicated.
- rst pulse at bin 15 → no out_wr after reset edge, all outputs zero, stray non-sop beats dropped, next frame completes normally.
